// File: rtl/mem_slice.sv
// MEM pipeline stage: latches EX outputs, runs the data-memory req/ack handshake
// with a timeout, stalls upstream while an access is outstanding and feeds WB.
module mem_slice #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int WBW     = 7,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WBW-1:0] WB_in,
    input  logic [1:0]     M_in,
    input  logic [AW-1:0]  addr_in,
    input  logic [DW-1:0]  data_in,
    input  logic [DW-1:0]  result_in,
    output logic           mem_req,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    input  logic [DW-1:0]  mem_rdata,
    output logic           stall,
    output logic [WBW-1:0] WB,
    output logic [DW-1:0]  rdata,
    output logic [DW-1:0]  result,
    output logic           mem_err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic           err_reg;

    logic [WBW-1:0] wb_q_reg;
    logic [1:0]     m_q_reg;
    logic [AW-1:0]  addr_q_reg;
    logic [DW-1:0]  data_q_reg;
    logic [DW-1:0]  result_q_reg;

    logic [WBW-1:0] wb_reg;
    logic [DW-1:0]  rdata_reg;
    logic [DW-1:0]  result_reg;

    logic access, is_wr, in_wait, req, timeout_hit, abort, complete, stall_int;

    assign access      = |m_q_reg;
    assign is_wr       = (m_q_reg == 2'b01);
    assign in_wait     = (state_reg == WAIT);
    assign req         = (!in_wait && access) || in_wait;
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
    assign abort       = in_wait && !mem_ack && timeout_hit;
    assign complete    = req && mem_ack;
    // The abort cycle releases the pipeline so the timed-out instruction retires.
    assign stall_int   = req && !mem_ack && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q_reg     <= '0;
            m_q_reg      <= '0;
            addr_q_reg   <= '0;
            data_q_reg   <= '0;
            result_q_reg <= '0;
        end else if (!stall_int) begin
            wb_q_reg     <= WB_in;
            m_q_reg      <= M_in;
            addr_q_reg   <= addr_in;
            data_q_reg   <= data_in;
            result_q_reg <= result_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access && !mem_ack) begin
                        state_reg <= WAIT;
                        cnt_reg   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (timeout_hit) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // A stalled cycle pushes a bubble so WB never sees the same instruction twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg     <= '0;
            rdata_reg  <= '0;
            result_reg <= '0;
        end else if (stall_int) begin
            wb_reg <= '0;
        end else begin
            wb_reg     <= wb_q_reg;
            result_reg <= result_q_reg;
            rdata_reg  <= (complete && !is_wr) ? mem_rdata : '0;
        end
    end

    assign mem_req   = req;
    assign mem_we    = is_wr;
    assign mem_addr  = addr_q_reg;
    assign mem_wdata = data_q_reg;
    assign stall     = stall_int;
    assign WB        = wb_reg;
    assign rdata     = rdata_reg;
    assign result    = result_reg;
    assign mem_err   = err_reg;
endmodule

// File: tb/tb_mem_slice.sv
// Self-checking bench for mem_slice: directed scenarios plus a randomized
// instruction stream checked against a per-instruction behavioural model.
module tb_mem_slice;
    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int WBW     = 7;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [WBW-1:0] WB_in;
    logic [1:0]     M_in;
    logic [AW-1:0]  addr_in;
    logic [DW-1:0]  data_in;
    logic [DW-1:0]  result_in;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_ack;
    logic [DW-1:0]  mem_rdata;
    logic           stall;
    logic [WBW-1:0] WB;
    logic [DW-1:0]  rdata;
    logic [DW-1:0]  result;
    logic           mem_err;

    mem_slice #(.DW(DW), .AW(AW), .WBW(WBW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .WB_in(WB_in), .M_in(M_in), .addr_in(addr_in),
        .data_in(data_in), .result_in(result_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .WB(WB), .rdata(rdata),
        .result(result), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction table: wait = number of unacknowledged request cycles (>= TIMEOUT: never acked)
    logic [1:0]     prog_m   [64];
    logic [WBW-1:0] prog_wb  [64];
    logic [AW-1:0]  prog_a   [64];
    logic [DW-1:0]  prog_d   [64];
    logic [DW-1:0]  prog_r   [64];
    logic [DW-1:0]  prog_rd  [64];
    int             prog_w   [64];
    int             prog_n = 0;

    // Model: instruction sitting in the MEM stage, plus the expected WB-side registers
    logic [1:0]     pm;
    logic [WBW-1:0] pwb;
    logic [AW-1:0]  pa;
    logic [DW-1:0]  pd, pr, prd;
    int             pw, rc;
    logic [WBW-1:0] m_wb;
    logic [DW-1:0]  m_rdata, m_result;
    logic           m_err;
    logic           stray_ack = 1'b0;

    int             n_req, n_stall, n_commit;
    logic [WBW-1:0] last_wb;
    logic [DW-1:0]  last_rdata, last_result;

    task automatic model_clear();
        pm = '0; pwb = '0; pa = '0; pd = '0; pr = '0; prd = '0; pw = 0; rc = 0;
        m_wb = '0; m_rdata = '0; m_result = '0; m_err = 1'b0;
    endtask

    task automatic add_instr(input logic [1:0] m, input logic [WBW-1:0] wb, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] r, input int w,
                             input logic [DW-1:0] rd);
        prog_m[prog_n] = m; prog_wb[prog_n] = wb; prog_a[prog_n] = a;
        prog_d[prog_n] = d; prog_r[prog_n] = r; prog_w[prog_n] = w; prog_rd[prog_n] = rd;
        prog_n++;
    endtask

    // Plays the EX stage and the memory; entered and left at posedge+1.
    task automatic run_program();
        int ex_i = 0;
        int guard = 0;
        int tail = 0;
        logic acc, ack, ab, xs;
        n_req = 0; n_stall = 0; n_commit = 0;
        last_wb = '0; last_rdata = '0; last_result = '0;
        while (tail < 2) begin
            if (ex_i < prog_n) begin
                WB_in = prog_wb[ex_i]; M_in = prog_m[ex_i]; addr_in = prog_a[ex_i];
                data_in = prog_d[ex_i]; result_in = prog_r[ex_i];
            end else begin
                WB_in = '0; M_in = '0; addr_in = '0; data_in = '0; result_in = '0;
            end
            acc = (pm != 2'b00);
            ack = acc && (rc == pw);
            ab  = acc && !ack && (rc == TIMEOUT - 1);
            xs  = acc && !ack && !ab;
            mem_ack   = ack ? 1'b1 : ((!acc && stray_ack) ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_rdata = ack ? prd : DW'($urandom);
            @(negedge clk);
            n_checks++;
            if (mem_req !== acc) begin n_fail++; $display("FAIL mem_req: got %b expected %b at %0t", mem_req, acc, $time); end
            n_checks++;
            if (stall !== xs) begin n_fail++; $display("FAIL stall: got %b expected %b at %0t", stall, xs, $time); end
            n_checks++;
            if (WB !== m_wb) begin n_fail++; $display("FAIL wb: got %h expected %h at %0t", WB, m_wb, $time); end
            n_checks++;
            if (rdata !== m_rdata) begin n_fail++; $display("FAIL rdata: got %h expected %h at %0t", rdata, m_rdata, $time); end
            n_checks++;
            if (result !== m_result) begin n_fail++; $display("FAIL result: got %h expected %h at %0t", result, m_result, $time); end
            n_checks++;
            if (mem_err !== m_err) begin n_fail++; $display("FAIL mem_err: got %b expected %b at %0t", mem_err, m_err, $time); end
            if (acc) begin
                n_checks++;
                if (mem_addr !== pa) begin n_fail++; $display("FAIL mem_addr: got %h expected %h at %0t", mem_addr, pa, $time); end
                n_checks++;
                if (mem_we !== (pm == 2'b01)) begin n_fail++; $display("FAIL mem_we: got %b expected %b at %0t", mem_we, pm == 2'b01, $time); end
                if (pm == 2'b01) begin
                    n_checks++;
                    if (mem_wdata !== pd) begin n_fail++; $display("FAIL mem_wdata: got %h expected %h at %0t", mem_wdata, pd, $time); end
                end
            end
            if (mem_req === 1'b1) n_req++;
            if (stall === 1'b1) n_stall++;
            if (WB !== '0) begin
                n_commit++; last_wb = WB; last_rdata = rdata; last_result = result;
                $display("retire wb=%h rdata=%h result=%h err=%b t=%0t", WB, rdata, result, mem_err, $time);
            end
            @(posedge clk);
            if (!xs) begin
                m_wb = pwb; m_result = pr;
                m_rdata = (ack && pm[1]) ? prd : '0;
                if (ab) m_err = 1'b1;
                if (ex_i < prog_n) begin
                    pm = prog_m[ex_i]; pwb = prog_wb[ex_i]; pa = prog_a[ex_i]; pd = prog_d[ex_i];
                    pr = prog_r[ex_i]; pw = prog_w[ex_i]; prd = prog_rd[ex_i];
                    ex_i++;
                end else begin
                    pm = '0; pwb = '0; pa = '0; pd = '0; pr = '0; pw = 0; prd = '0;
                end
                rc = 0;
            end else begin
                m_wb = '0;
                rc++;
            end
            #1;
            if (ex_i >= prog_n && pm == 2'b00) tail++;
            guard++;
            if (guard > 2000) begin
                n_checks++; n_fail++;
                $display("FAIL program_bound: got %0d cycles expected at most 2000", guard);
                tail = 2;
            end
        end
        prog_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        WB_in = 7'h7F; M_in = 2'b11; addr_in = 16'hFFFF; data_in = 16'hFFFF; result_in = 16'hFFFF;
        mem_ack = 1'b1; mem_rdata = 16'hABCD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_req, stall, mem_we, mem_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, stall, mem_we, mem_err});
        end
        n_checks++;
        if ({WB, rdata, result} !== '0) begin
            n_fail++; $display("FAIL reset_data: got wb=%h rdata=%h result=%h expected all zero", WB, rdata, result);
        end
        WB_in = '0; M_in = '0; addr_in = '0; data_in = '0; result_in = '0; mem_ack = 1'b0;
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_read_zero_wait();
        add_instr(2'b10, 7'h55, 16'h0040, 16'h0000, 16'h0AAA, 0, 16'h1234);
        run_program();
        n_checks++;
        if (n_stall != 0) begin n_fail++; $display("FAIL rd0_stall: got %0d expected 0", n_stall); end
        n_checks++;
        if (n_commit != 1 || last_wb !== 7'h55 || last_rdata !== 16'h1234) begin
            n_fail++; $display("FAIL rd0_commit: got n=%0d wb=%h rdata=%h expected n=1 wb=55 rdata=1234", n_commit, last_wb, last_rdata);
        end
    endtask

    task automatic test_read_wait3();
        add_instr(2'b10, 7'h2A, 16'h0040, 16'h0000, 16'h0BBB, 3, 16'h5678);
        run_program();
        n_checks++;
        if (n_stall != 3 || n_req != 4) begin
            n_fail++; $display("FAIL rd3_cycles: got stall=%0d req=%0d expected stall=3 req=4", n_stall, n_req);
        end
        n_checks++;
        if (n_commit != 1 || last_rdata !== 16'h5678 || last_result !== 16'h0BBB) begin
            n_fail++; $display("FAIL rd3_commit: got n=%0d rdata=%h result=%h expected n=1 rdata=5678 result=0bbb", n_commit, last_rdata, last_result);
        end
    endtask

    task automatic test_write();
        add_instr(2'b01, 7'h33, 16'h0010, 16'hBEEF, 16'h0CCC, 1, 16'hDEAD);
        run_program();
        n_checks++;
        if (n_stall != 1) begin n_fail++; $display("FAIL wr_stall: got %0d expected 1", n_stall); end
        n_checks++;
        if (n_commit != 1 || last_rdata !== 16'h0000 || last_result !== 16'h0CCC) begin
            n_fail++; $display("FAIL wr_commit: got n=%0d rdata=%h result=%h expected n=1 rdata=0000 result=0ccc", n_commit, last_rdata, last_result);
        end
    endtask

    task automatic test_back_to_back();
        add_instr(2'b10, 7'h11, 16'h0100, 16'h0000, 16'h1111, 0, 16'hAAAA);
        add_instr(2'b01, 7'h12, 16'h0200, 16'h5555, 16'h2222, 0, 16'h0000);
        run_program();
        n_checks++;
        if (n_req != 2 || n_stall != 0 || n_commit != 2) begin
            n_fail++; $display("FAIL b2b: got req=%0d stall=%0d commits=%0d expected 2/0/2", n_req, n_stall, n_commit);
        end
    endtask

    task automatic test_timeout();
        add_instr(2'b10, 7'h44, 16'h0300, 16'h0000, 16'h3333, 99, 16'h9999);
        run_program();
        n_checks++;
        if (n_req != TIMEOUT || n_stall != TIMEOUT - 1) begin
            n_fail++; $display("FAIL to_cycles: got req=%0d stall=%0d expected req=%0d stall=%0d", n_req, n_stall, TIMEOUT, TIMEOUT - 1);
        end
        n_checks++;
        if (n_commit != 1 || last_rdata !== 16'h0000 || mem_err !== 1'b1) begin
            n_fail++; $display("FAIL to_commit: got n=%0d rdata=%h err=%b expected n=1 rdata=0000 err=1", n_commit, last_rdata, mem_err);
        end
        add_instr(2'b11, 7'h45, 16'h0304, 16'h0000, 16'h3334, 0, 16'h4321);
        run_program();
        n_checks++;
        if (mem_err !== 1'b1 || last_rdata !== 16'h4321) begin
            n_fail++; $display("FAIL to_sticky: got err=%b rdata=%h expected err=1 rdata=4321", mem_err, last_rdata);
        end
    endtask

    task automatic test_random();
        int r, w;
        stray_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            w = (r < 7) ? (r % 4) : ((r == 9) ? 50 : 0);
            add_instr(2'($urandom), WBW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), w, DW'($urandom));
        end
        run_program();
        stray_ack = 1'b0;
    endtask

    task automatic test_rst_mid_wait();
        WB_in = 7'h11; M_in = 2'b01; addr_in = 16'h0020; data_in = 16'h0101; result_in = 16'h7777;
        mem_ack = 1'b1; mem_rdata = '0;
        @(posedge clk); #1;
        WB_in = 7'h22; M_in = 2'b10; addr_in = 16'h0040; data_in = '0; result_in = 16'h2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        WB_in = '0; M_in = '0; addr_in = '0; data_in = '0; result_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({mem_req, stall, mem_err} !== {2'b11, m_err} || result !== 16'h7777 || mem_addr !== 16'h0040) begin
            n_fail++; $display("FAIL prerst: got req=%b stall=%b err=%b result=%h addr=%h expected 1 1 %b 7777 0040",
                               mem_req, stall, mem_err, result, mem_addr, m_err);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, stall, mem_we, mem_err} !== 4'b0000 || {WB, rdata, result} !== '0) begin
            n_fail++; $display("FAIL async_rst: got req=%b stall=%b we=%b err=%b wb=%h rdata=%h result=%h expected all zero",
                               mem_req, stall, mem_we, mem_err, WB, rdata, result);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hFACE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_req, stall, mem_err} !== 3'b000 || WB !== '0 || rdata !== '0) begin
                n_fail++; $display("FAIL stray_ack: got req=%b stall=%b err=%b wb=%h rdata=%h expected all zero",
                                   mem_req, stall, mem_err, WB, rdata);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_read_zero_wait();
        test_read_wait3();
        test_write();
        test_back_to_back();
        test_timeout();
        test_random();
        test_rst_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
